// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter that shares one serial BRAM bus slave between
// NUM_MASTERS serial masters. One master at a time owns the bus. The owner's
// serial lines are muxed onto the slave. The slave's read-back lines are
// returned to the owner only.
//
// Parameters
//   NUM_MASTERS  number of requesting masters (>= 2)
//   TIMEOUT      maximum number of cycles one master may hold the grant (>= 32)
//   MB           width of the owner index (derived)
//
// Ports
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   m_req        per-master request, held high for a whole transaction
//   m_valid      per-master serial valid
//   m_wren       per-master write enable
//   m_addr       per-master serial address bit
//   m_data       per-master serial write-data bit
//   m_grant      registered one-hot grant
//   m_rvalid     slave validOut, routed to the owner only
//   m_rdata      slave DataOut, routed to the owner only
//   s_ready      slave ready; no new grant is issued while it is low
//   s_validOut   slave read-valid
//   s_dataOut    slave serial read data
//   bus_valid    to slave validIn
//   bus_wren     to slave wren
//   bus_addr     to slave Address
//   bus_data     to slave DataIn
//   busy         high while any grant is active
//   owner        index of the current owner, or of the last owner
//   timeout_err  one-cycle pulse after a forced release
//
// Build option
//   ARB_TIMEOUT_EN  When defined, the arbiter counts how long the grant has
//                   been held and forces a release after TIMEOUT cycles.
//                   When undefined, a grant ends only when the owner drops
//                   its request, and timeout_err is tied low.
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter  int NUM_MASTERS = 2,
  parameter  int TIMEOUT     = 64,
  localparam int MB          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] m_req,
  input  logic [NUM_MASTERS-1:0] m_valid,
  input  logic [NUM_MASTERS-1:0] m_wren,
  input  logic [NUM_MASTERS-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0] m_data,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [NUM_MASTERS-1:0] m_rvalid,
  output logic [NUM_MASTERS-1:0] m_rdata,
  input  logic                   s_ready,
  input  logic                   s_validOut,
  input  logic                   s_dataOut,
  output logic                   bus_valid,
  output logic                   bus_wren,
  output logic                   bus_addr,
  output logic                   bus_data,
  output logic                   busy,
  output logic [MB-1:0]          owner,
  output logic                   timeout_err
);

  // Reject illegal parameter values when the design is elaborated.
  if (NUM_MASTERS < 2) begin : gBadMasters
    $error("bus_arbiter: NUM_MASTERS must be at least 2");
  end
  if (TIMEOUT < 32) begin : gBadTimeout
    $error("bus_arbiter: TIMEOUT must be at least 32");
  end

  // RELEASE is a turnaround cycle. The slave sees bus_valid low for at least
  // one full cycle between two owners.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arbState_t;

  localparam logic [MB-1:0] LAST_IDX = MB'(NUM_MASTERS - 1);

  arbState_t            state, stateNext;
  logic [NUM_MASTERS-1:0] grantNext;
  logic [MB-1:0]        ownerNext;
  logic [MB-1:0]        lastPtr, lastPtrNext;
  logic                 errNext;
  logic                 winnerFound;
  logic [MB-1:0]        winnerIdx;
  logic                 timeoutHit;

`ifdef ARB_TIMEOUT_EN
  // Wide enough to hold TIMEOUT itself, the saturation value.
  localparam int HW = $clog2(TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(TIMEOUT);
  localparam logic [HW-1:0] HOLD_LAST = HW'(TIMEOUT - 1);

  logic [HW-1:0] holdCnt, holdNext;

  // holdCnt reaches TIMEOUT-1 in the TIMEOUT-th cycle of a grant.
  assign timeoutHit = (state == BUSY) && (holdCnt == HOLD_LAST);
`else
  assign timeoutHit = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Round-robin winner search. Scan upward from the slot after the last
  // owner and wrap around. The last owner is checked last, so a master that
  // keeps requesting gets the bus again only if nobody else wants it.
  // -------------------------------------------------------------------------
  always_comb begin
    logic [MB-1:0] cand;
    winnerFound = 1'b0;
    winnerIdx   = lastPtr;
    cand        = lastPtr;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = MB'((int'(lastPtr) + k) % NUM_MASTERS);
      if (!winnerFound && m_req[cand]) begin
        winnerFound = 1'b1;
        winnerIdx   = cand;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State register. The grant, owner, pointer and error flag are updated
  // together with the state, so every registered output changes on the same
  // edge as the state.
  // NOTE: all sequential state uses non-blocking assignments. Every register
  // then samples the values from before the edge, and the result does not
  // depend on the order in which the simulator runs the processes.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      m_grant     <= '0;
      owner       <= LAST_IDX;
      lastPtr     <= LAST_IDX;
      timeout_err <= 1'b0;
    end else begin
      state       <= stateNext;
      m_grant     <= grantNext;
      owner       <= ownerNext;
      lastPtr     <= lastPtrNext;
      timeout_err <= errNext;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) holdCnt <= '0;
    else       holdCnt <= holdNext;
  end
`endif

  // -------------------------------------------------------------------------
  // Next-state logic.
  // NOTE: every signal is given its hold value before the case statement.
  // Each branch then only overrides what changes, and a missed assignment
  // cannot infer a latch.
  // -------------------------------------------------------------------------
  always_comb begin
    stateNext   = state;
    grantNext   = m_grant;
    ownerNext   = owner;
    lastPtrNext = lastPtr;
    errNext     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    holdNext    = holdCnt;
`endif

    unique case (state)
      IDLE: begin
        // A grant is only issued when the slave can accept a transaction.
        if (winnerFound && s_ready) begin
          grantNext            = '0;
          grantNext[winnerIdx] = 1'b1;
          ownerNext            = winnerIdx;
          stateNext            = BUSY;
`ifdef ARB_TIMEOUT_EN
          holdNext             = '0;
`endif
        end
      end

      BUSY: begin
`ifdef ARB_TIMEOUT_EN
        if (holdCnt != HOLD_MAX) holdNext = holdCnt + 1'b1;
`endif
        // The owner's own release takes priority. If it drops its request in
        // the cycle the timeout hits, this is a normal release and no error
        // is flagged.
        if (!m_req[owner]) begin
          grantNext = '0;
          stateNext = RELEASE;
        end else if (timeoutHit) begin
          grantNext = '0;
          errNext   = 1'b1;
          stateNext = RELEASE;
        end
      end

      RELEASE: begin
        lastPtrNext = owner;
        stateNext   = IDLE;
      end

      default: begin
        grantNext = '0;
        stateNext = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic. The mux paths are purely combinational and are gated by the
  // registered grant. They add no latency, and they read as zero whenever no
  // master holds the grant.
  // -------------------------------------------------------------------------
  always_comb begin
    bus_valid = |(m_grant & m_valid);
    bus_wren  = |(m_grant & m_wren);
    bus_addr  = |(m_grant & m_addr);
    bus_data  = |(m_grant & m_data);
    m_rvalid  = m_grant & {NUM_MASTERS{s_validOut}};
    m_rdata   = m_grant & {NUM_MASTERS{s_dataOut}};
    busy      = |m_grant;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Self-checking bench for bus_arbiter with three masters. Random requests and
// random serial traffic drive the arbiter. A transaction-level reference
// model predicts the result: it tracks who owns the bus, how long the owner
// has held it, who was served last and how many dead cycles are left before
// the next grant. A few directed scenarios cover reset, slave not ready, the
// forced-release timeout and reset in the middle of a transaction.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int N   = 3;
  localparam int TMO = 40;
  localparam int MBW = $clog2(N);
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   m_req, m_valid, m_wren, m_addr, m_data;
  logic [N-1:0]   m_grant, m_rvalid, m_rdata;
  logic           s_ready, s_validOut, s_dataOut;
  logic           bus_valid, bus_wren, bus_addr, bus_data, busy, timeout_err;
  logic [MBW-1:0] owner;

  bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .m_req(m_req), .m_valid(m_valid), .m_wren(m_wren),
    .m_addr(m_addr), .m_data(m_data),
    .m_grant(m_grant), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .s_ready(s_ready), .s_validOut(s_validOut), .s_dataOut(s_dataOut),
    .bus_valid(bus_valid), .bus_wren(bus_wren),
    .bus_addr(bus_addr), .bus_data(bus_data),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int   curOwner;    // -1 when nobody holds the bus
  int   lastServed;  // last master whose grant has ended
  int   cooldown;    // dead cycles still to pass before arbitration
  int   held;        // edges counted since the grant was issued
  int   expOwner;
  logic expErr;

  task automatic modelReset();
    curOwner   = -1;
    lastServed = N - 1;
    cooldown   = 0;
    held       = 0;
    expOwner   = N - 1;
    expErr     = 1'b0;
  endtask

  task automatic endGrant(input logic forced);
    lastServed = curOwner;
    curOwner   = -1;
    cooldown   = 1;
    expErr     = forced;
  endtask

  // Called once per rising edge. It uses the inputs that were stable before
  // that edge.
  task automatic modelStep();
    expErr = 1'b0;
    if (curOwner >= 0) begin
      held++;
      if (!m_req[curOwner])              endGrant(1'b0);
      else if (TO_EN && held == TMO)     endGrant(1'b1);
    end else if (cooldown > 0) begin
      cooldown--;
    end else if (s_ready && (m_req != '0)) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (lastServed + k) % N;
        if (curOwner < 0 && m_req[c]) curOwner = c;
      end
      expOwner = curOwner;
      held     = 0;
    end
  endtask

  function automatic logic [N-1:0] expGrant();
    logic [N-1:0] g;
    g = '0;
    if (curOwner >= 0) g[curOwner] = 1'b1;
    return g;
  endfunction

  function automatic logic ownBit(input logic [N-1:0] v);
    return (curOwner >= 0) ? v[curOwner] : 1'b0;
  endfunction

  task automatic checkRegs(input string tag);
    check({tag, ".grant"}, m_grant, expGrant());
    check({tag, ".owner"}, owner, expOwner);
    check({tag, ".terr"}, timeout_err, expErr);
    check({tag, ".busy"}, busy, curOwner >= 0);
  endtask

  task automatic checkComb(input string tag);
    check({tag, ".bvalid"}, bus_valid, ownBit(m_valid));
    check({tag, ".bwren"}, bus_wren, ownBit(m_wren));
    check({tag, ".baddr"}, bus_addr, ownBit(m_addr));
    check({tag, ".bdata"}, bus_data, ownBit(m_data));
    check({tag, ".rvalid"}, m_rvalid, s_validOut ? expGrant() : '0);
    check({tag, ".rdata"}, m_rdata, s_dataOut ? expGrant() : '0);
  endtask

  // Drives one cycle: applies the requests, the slave-ready bit and random
  // serial traffic, checks the mux paths, then takes the edge and checks the
  // registered outputs.
  task automatic cycle(input logic [N-1:0] reqV, input logic readyV);
    m_req      = reqV;
    s_ready    = readyV;
    m_valid    = N'($urandom);
    m_wren     = N'($urandom);
    m_addr     = N'($urandom);
    m_data     = N'($urandom);
    s_validOut = 1'($urandom);
    s_dataOut  = 1'($urandom);
    #1;
    checkComb("mux");
    @(posedge clk);
    modelStep();
    #1;
    checkRegs("reg");
  endtask

  // ---------------- random request generator ----------------
  int reqLeft [N];
  int idleLeft[N];
  logic [N-1:0] rndReq;

  task automatic nextRandomReq();
    for (int i = 0; i < N; i++) begin
      if (rndReq[i]) begin
        reqLeft[i]--;
        if (reqLeft[i] <= 0) begin
          rndReq[i]   = 1'b0;
          idleLeft[i] = $urandom_range(0, 6);
        end
      end else if (idleLeft[i] > 0) begin
        idleLeft[i]--;
      end else begin
        rndReq[i]  = 1'b1;
        reqLeft[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(45, 80)
                                                 : $urandom_range(3, 35);
      end
    end
  endtask

  initial begin
    rndReq = '0;
    for (int i = 0; i < N; i++) begin
      reqLeft[i]  = 0;
      idleLeft[i] = $urandom_range(0, 4);
    end
    m_req = '0; s_ready = 1'b1;
    m_valid = '1; m_wren = '1; m_addr = '1; m_data = '1;
    s_validOut = 1'b1; s_dataOut = 1'b1;
    rstn = 1'b1;
    #1 rstn = 1'b0;

    // Reset state. Every output is zero except owner, which is N-1.
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkRegs("rst");
    checkComb("rst");
    check("rst.owner_const", owner, N - 1);
    @(negedge clk) rstn = 1'b1;

    // The first request wins on the next edge, and the mux follows master 0.
    cycle(3'b001, 1'b1);
    check("first.grant", m_grant, 3'b001);
    check("first.owner", owner, 0);
    repeat (6) cycle(3'b001, 1'b1);
    repeat (4) cycle(3'b000, 1'b1);

    // While the slave is not ready, no grant is issued. The grant follows on
    // the first edge after ready rises.
    repeat (4) cycle(3'b010, 1'b0);
    check("noready.grant", m_grant, 3'b000);
    cycle(3'b010, 1'b1);
    check("ready.grant", m_grant, 3'b010);
    repeat (5) cycle(3'b010, 1'b1);
    repeat (4) cycle(3'b000, 1'b1);

    // Random traffic, including holds longer than TIMEOUT.
    for (int n = 0; n < 3000; n++) begin
      nextRandomReq();
      cycle(rndReq, ($urandom_range(0, 9) != 0));
    end
    repeat (4) cycle(3'b000, 1'b1);

    // Two masters request at the same time. Master 0 keeps requesting for
    // 100 cycles. Master 1 requests throughout.
    for (int n = 0; n < 100; n++) cycle(3'b011, 1'b1);
    for (int n = 0; n < 60; n++)  cycle(3'b010, 1'b1);
    repeat (4) cycle(3'b000, 1'b1);

    // Reset in the middle of a transaction owned by master 1.
    begin
      int tries = 0;
      while (curOwner != 1 && tries < 10) begin
        cycle(3'b010, 1'b1);
        tries++;
      end
      check("midrst.pre_grant", m_grant, 3'b010);
    end
    m_valid = '1;
    #2 rstn = 1'b0;
    #1;
    check("midrst.grant", m_grant, 3'b000);
    check("midrst.bvalid", bus_valid, 1'b0);
    check("midrst.busy", busy, 1'b0);
    modelReset();
    @(negedge clk) rstn = 1'b1;
    cycle(3'b011, 1'b1);
    check("postrst.grant", m_grant, 3'b001);
    repeat (5) cycle(3'b011, 1'b1);
    repeat (4) cycle(3'b000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net: stop the run if the stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter sharing one serial bus slave (BRAM slave: serial address/data shift-in, serial read-out) between NUM_MASTERS serial masters.
- Grants the bus to one master at a time and muxes that master's serial lines onto the slave.
- Routes the slave's serial read data back to the owner only.
- Sits between the master ports and the slave in the bus top level.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (>=2).
- TIMEOUT, 64, maximum cycles one master may hold the grant; must be at least 32 (longer than one full transaction).
- MB, $clog2(NUM_MASTERS), width of owner index (localparam).

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- m_req  in  NUM_MASTERS  per-master bus request; held high for the whole transaction
- m_valid  in  NUM_MASTERS  per-master serial valid
- m_wren  in  NUM_MASTERS  per-master write enable
- m_addr  in  NUM_MASTERS  per-master serial address bit
- m_data  in  NUM_MASTERS  per-master serial write-data bit
- m_grant  out  NUM_MASTERS  one-hot grant, registered
- m_rvalid  out  NUM_MASTERS  slave validOut, routed to the owner only
- m_rdata  out  NUM_MASTERS  slave DataOut, routed to the owner only
- s_ready  in  1  slave ready
- s_validOut  in  1  slave read-valid
- s_dataOut  in  1  slave serial read data
- bus_valid  out  1  to slave validIn
- bus_wren  out  1  to slave wren
- bus_addr  out  1  to slave Address
- bus_data  out  1  to slave DataIn
- busy  out  1  high while any grant is active
- owner  out  MB  index of the current or last owner
- timeout_err  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE, m_grant=0, owner=NUM_MASTERS-1, last pointer=NUM_MASTERS-1.
  - Hold counter=0, timeout_err=0.
  - All bus_* and m_rvalid/m_rdata are therefore 0.
- Mux paths are combinational, gated by the registered m_grant; no extra latency through the arbiter.
  - bus_x = OR over i of (m_grant[i] & m_x[i]), giving 0 with no grant.
  - m_rvalid[i] = m_grant[i] & s_validOut; m_rdata[i] = m_grant[i] & s_dataOut.
- States are IDLE, BUSY and RELEASE (2-bit encoding).
- IDLE:
  - If |m_req and s_ready: pick the winner, set m_grant[w]=1, owner=w, counter=0, and go to BUSY. Grant rises on the edge after req is sampled (1-cycle latency).
  - Winner search: first requester scanning upward from (last pointer+1) mod NUM_MASTERS, wrapping.
  - If s_ready=0: no grant; stay in IDLE regardless of requests.
- BUSY:
  - Each cycle, counter increments (saturating at TIMEOUT).
  - If m_req[owner]=0: clear m_grant and go to RELEASE.
  - Else if counter==TIMEOUT-1 (grant has been held for TIMEOUT cycles): clear m_grant, set timeout_err=1, and go to RELEASE.
  - Requests from other masters are ignored; no preemption.
- RELEASE:
  - Turnaround cycle with m_grant=0 and the slave sees bus_valid=0.
  - Last pointer updates to owner; timeout_err clears; go to IDLE.
  - Minimum gap between two grants is therefore 2 idle-bus cycles.
- Simultaneous req drop and timeout in the same cycle: treated as a normal release; timeout_err stays 0.
- Owner holding req after a timeout: not re-granted until another requester has been served. If it is the only requester, it is re-granted in the following IDLE.
- Reset mid-transaction: grant drops immediately and bus_* go to 0. The slave FSM is not reset by this block; masters must restart.
- busy = |m_grant.
- owner holds its value outside BUSY.

Optional Feature:
- ARB_TIMEOUT_EN
  - Defined: hold counter and forced release as above; timeout_err pulses.
  - Undefined: no counter logic; BUSY exits only on the owner's req drop; timeout_err tied to 0.

Test Plan:
- Reset, then m_req=01 with s_ready=1 -> m_grant=01 one cycle later, owner=0; bus_addr follows m_addr[0] bit-for-bit; m_addr[1] has no effect.
- m_req=11 held continuously, each master dropping req after 30 cycles then re-raising -> grants alternate 01,10,01,10, each separated by exactly 2 cycles of m_grant=00.
- Master 1 read transaction while master 0 idle -> s_validOut/s_dataOut appear only on m_rvalid[1]/m_rdata[1]; m_rvalid[0]=0 throughout.
- s_ready=0 with m_req=10 -> m_grant stays 00; s_ready=1 -> m_grant=10 on the next edge.
- With ARB_TIMEOUT_EN and TIMEOUT=64, master 0 holds req for 100 cycles while master 1 requests:
  - Grant drops after 64 cycles and timeout_err pulses for 1 cycle.
  - m_grant=10 two cycles later.
- rstn pulsed low while m_grant=10 -> m_grant=00 and bus_valid=0 asynchronously; after release, m_req=11 grants master 0 first.
